// File: rtl/thermostat_fsm_multi.sv
// Purpose: per-zone hysteresis heating/cooling controller with minimum dwell, global mode and sensor-fault flag.
// Latency: one cycle; temp/mode sampled at a rising edge, state and demands are Moore decodes of the registers.
// Backpressure: none; every zone is re-evaluated on every edge and outputs are always valid.
module thermostat_fsm_multi #(
  parameter int TEMP_W     = 5,
  parameter int N_ZONES    = 2,
  parameter int HEAT_ON    = 18,
  parameter int COOL_ON    = 22,
  parameter int SETPOINT   = 20,
  parameter int MIN_DWELL  = 4,
  parameter int FAULT_CODE = 2**TEMP_W-1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                mode,
  input  logic [N_ZONES*TEMP_W-1:0] temp,
  output logic [N_ZONES-1:0]        heating,
  output logic [N_ZONES-1:0]        cooling,
  output logic [2*N_ZONES-1:0]      state,
  output logic [N_ZONES-1:0]        fault
);

  // Thresholds live in the temperature domain, so they are truncated to TEMP_W.
  localparam logic [TEMP_W-1:0] HEAT_T  = TEMP_W'(HEAT_ON);
  localparam logic [TEMP_W-1:0] COOL_T  = TEMP_W'(COOL_ON);
  localparam logic [TEMP_W-1:0] SET_T   = TEMP_W'(SETPOINT);
  localparam logic [TEMP_W-1:0] FAULT_T = TEMP_W'(FAULT_CODE);

  // Dwell counter saturates at MIN_DWELL; leaving is allowed once it reaches MIN_DWELL-1.
  localparam int              DW        = $clog2(MIN_DWELL + 1);
  localparam logic [DW-1:0]   DWELL_MAX = DW'(MIN_DWELL);
  localparam logic [DW-1:0]   DWELL_OK  = DW'(MIN_DWELL - 1);

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_HEAT = 2'b01;
  localparam logic [1:0] MODE_COOL = 2'b10;
  localparam logic [1:0] MODE_AUTO = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HEAT = 2'b01,
    ST_COOL = 2'b10
  } state_t;

  // Reject parameter sets that would break the hysteresis band or the dwell logic.
  if (!((HEAT_T < SET_T) && (SET_T < COOL_T))) begin : g_bad_thresholds
    $error("thermostat_fsm_multi: need HEAT_ON < SETPOINT < COOL_ON after truncation to TEMP_W");
  end
  if (MIN_DWELL < 1) begin : g_bad_dwell
    $error("thermostat_fsm_multi: MIN_DWELL must be >= 1");
  end
  if ((N_ZONES < 1) || (N_ZONES > 8)) begin : g_bad_zones
    $error("thermostat_fsm_multi: N_ZONES must be in 1..8");
  end

  logic heat_allowed;
  logic cool_allowed;

  assign heat_allowed = (mode == MODE_HEAT) || (mode == MODE_AUTO);
  assign cool_allowed = (mode == MODE_COOL) || (mode == MODE_AUTO);

  for (genvar z = 0; z < N_ZONES; z++) begin : g_zone
    state_t            cur_q;
    state_t            nxt;
    logic [DW-1:0]     dwell_q;
    logic              fault_q;
    logic [TEMP_W-1:0] t;
    logic              is_fault;
    logic              dwell_ok;
    logic              heat_d;
    logic              cool_d;

    assign t        = temp[z*TEMP_W +: TEMP_W];
    assign is_fault = (t == FAULT_T);
    assign dwell_ok = (dwell_q >= DWELL_OK);

    // Next-state selection in priority order, plus Moore output decode.
    always_comb begin
      nxt    = cur_q;
      heat_d = 1'b0;
      cool_d = 1'b0;
      if (is_fault || (mode == MODE_OFF)) begin
        nxt = ST_IDLE;
      end else begin
        case (cur_q)
          ST_IDLE: begin
            if (dwell_ok && (t <= HEAT_T) && heat_allowed) begin
              nxt = ST_HEAT;
            end else if (dwell_ok && (t >= COOL_T) && cool_allowed) begin
              nxt = ST_COOL;
            end
          end
          ST_HEAT: begin
            if (mode == MODE_COOL) begin
              nxt = ST_IDLE;
            end else if (dwell_ok && (t >= SET_T)) begin
              nxt = ST_IDLE;
            end
          end
          ST_COOL: begin
            if (mode == MODE_HEAT) begin
              nxt = ST_IDLE;
            end else if (dwell_ok && (t <= SET_T)) begin
              nxt = ST_IDLE;
            end
          end
          default: nxt = ST_IDLE;
        endcase
      end
      heat_d = (cur_q == ST_HEAT);
      cool_d = (cur_q == ST_COOL);
    end

    // State, dwell and fault registers; the dwell restarts on a state change,
    // while the sensor is faulted, and on the edge the fault clears.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cur_q   <= ST_IDLE;
        dwell_q <= DWELL_MAX;
        fault_q <= 1'b0;
      end else begin
        cur_q   <= nxt;
        fault_q <= is_fault;
        if ((nxt != cur_q) || is_fault || fault_q) begin
          dwell_q <= '0;
        end else if (dwell_q != DWELL_MAX) begin
          dwell_q <= dwell_q + DW'(1);
        end
      end
    end

    assign heating[z]        = heat_d;
    assign cooling[z]        = cool_d;
    assign state[2*z +: 2]   = cur_q;
    assign fault[z]          = fault_q;
  end

endmodule

// File: doc/thermostat_fsm_multi.md
Name: thermostat_fsm_multi

Overview:
- Multi-zone, parametrised successor to the single-zone heating/cooling (AC) controller.
- Runs one independent hysteresis FSM per zone. Each FSM takes that zone's temperature and drives registered heating/cooling demands.
- Adds four features:
  - programmable thresholds;
  - a minimum-dwell timer that protects the compressor and heater;
  - a global operating mode;
  - a per-zone sensor-fault flag.
- Sits between the zone temperature sensors and the heater/cooler drive logic.

Parameters:
- TEMP_W, 5, temperature width in bits (unsigned).
- N_ZONES, 2, number of independent zones (1..8).
- HEAT_ON, 18, heating starts when temp <= HEAT_ON.
- COOL_ON, 22, cooling starts when temp >= COOL_ON.
- SETPOINT, 20, heating stops at temp >= SETPOINT; cooling stops at temp <= SETPOINT.
- MIN_DWELL, 4, minimum clock cycles spent in any state before leaving it (>=1).
- FAULT_CODE, 2**TEMP_W-1, sensor reading that signals sensor failure.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  2  00=OFF, 01=HEAT_ONLY, 10=COOL_ONLY, 11=AUTO; shared by all zones.
- temp  in  N_ZONES*TEMP_W  packed zone temperatures; zone i at bits [i*TEMP_W +: TEMP_W].
- heating  out  N_ZONES  per-zone heater demand.
- cooling  out  N_ZONES  per-zone cooler demand.
- state  out  2*N_ZONES  per-zone state code: 00=IDLE, 01=HEAT, 10=COOL, 11 unused.
- fault  out  N_ZONES  per-zone sensor fault, sticky until temp leaves FAULT_CODE.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all zones go to IDLE;
  - heating=0, cooling=0, fault=0;
  - dwell counters are loaded with MIN_DWELL (dwell satisfied), so the first transition after reset is not delayed.
- Outputs are Moore decodes of the registered state:
  - heating=1 only in HEAT; cooling=1 only in COOL;
  - heating and cooling are never both 1 in the same zone.
- Latency: temp sampled at rising edge k; new state and outputs visible after edge k; one cycle, combinationally stable.
- Per-zone dwell counter:
  - reset to 0 on every state change;
  - increments each cycle, saturating at MIN_DWELL;
  - "dwell_ok" = counter >= MIN_DWELL-1 (i.e. at least MIN_DWELL cycles in the current state at the transition edge).
- Transitions, evaluated per zone each edge, in priority order:
  1. temp == FAULT_CODE: next = IDLE immediately (dwell ignored); fault=1.
  2. mode == OFF: next = IDLE immediately (dwell ignored).
  3. IDLE: if dwell_ok and temp <= HEAT_ON and mode is HEAT_ONLY or AUTO -> HEAT. Else if dwell_ok and temp >= COOL_ON and mode is COOL_ONLY or AUTO -> COOL. Else stay.
  4. HEAT: if mode == COOL_ONLY -> IDLE immediately. Else if dwell_ok and temp >= SETPOINT -> IDLE. Else stay.
  5. COOL: if mode == HEAT_ONLY -> IDLE immediately. Else if dwell_ok and temp <= SETPOINT -> IDLE. Else stay.
- HEAT<->COOL directly is forbidden; a zone always passes through IDLE, including its dwell.
- fault clears on the first edge where temp != FAULT_CODE. Normal FSM evaluation resumes from IDLE on the same edge, with the dwell restarting from 0.
- Comparisons are unsigned over TEMP_W bits. Thresholds are truncated to TEMP_W. Parameter legality (HEAT_ON < SETPOINT < COOL_ON) is checked at elaboration; violation is a $error.
- Zones are fully independent; no shared counters.
- Reset asserted mid-dwell or mid-HEAT/COOL: outputs drop asynchronously to 0 within the reset assertion.

Test Plan:
- Reset, mode=AUTO, zone0 temp=15 -> after release, heating[0]=1 at the first edge; heating[0]=0 held throughout reset.
- Zone0 in HEAT, temp steps 15->19->20 -> heating stays 1 at 19; IDLE one edge after temp=20 once MIN_DWELL=4 cycles have elapsed in HEAT.
- Zone1 temp=25 while zone0 temp=20, AUTO -> cooling[1]=1 while zone0 stays IDLE. Then temp1=21 -> stays COOL (hysteresis); temp1=20 -> IDLE.
- Dwell: enter HEAT, then temp=24 on the next cycle -> HEAT held until 4 cycles in HEAT, then IDLE. Next, with temp still 24, COOL is reached only after 4 more cycles in IDLE. heating and cooling never both 1.
- Mode: zone in COOL, mode switched to HEAT_ONLY -> IDLE on the next edge regardless of dwell. mode=OFF with temp=10 -> no heating.
- Fault: temp0=31 (FAULT_CODE) while in HEAT -> fault[0]=1, heating[0]=0 next edge. temp0=15 -> fault clears, HEAT re-entered after 4 cycles.
